// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// A start bit is confirmed at its midpoint, which rejects line glitches shorter
// than half a bit. Framing errors and FIFO overruns are reported as sticky flags.
//
// Read handshake: rd_valid means rd_data holds the oldest queued byte; a byte is
// consumed on a rising clk edge where rd_en and rd_valid are both 1. rd_en is
// ignored while rd_valid is 0. There is no backpressure on the serial side, so
// a byte completed while the FIFO is full and not being read is dropped.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic [2:0]                    dbg_state_o
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [PW-1:0]    DEPTH_P = PW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // Synchroniser
    logic rx_meta_q;
    logic rxs_q;

    // Receiver
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             baud_tick;
    logic             push;
    logic             fe_set;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          ovr_set;

    // Flags
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    assign baud_tick = (cnt_q == '0);

    // Receiver state register; reset drops any partially received byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Receiver next-state: bit sampling at mid-bit via the down-counting baud timer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        fe_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                        cnt_d     = DIV_M1;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d[bit_idx_q] = rxs_q;
                    cnt_d              = DIV_M1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                // Hold off while the line is in a break condition.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dbg_state_o = state_q;

    // FIFO control: a pop frees a slot in the same cycle, so push+pop when full succeeds.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign rd_valid  = (count != '0);
    assign fifo_full = (count == DEPTH_P);
    assign pop       = rd_en & rd_valid;
    assign push_ok   = push & (~fifo_full | pop);
    assign ovr_set   = push & fifo_full & ~pop;
    assign rd_data   = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

    // Pointer next-state; the extra MSB distinguishes full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // Sticky flag next-state: a new error in the same cycle as clr_err wins.
    always_comb begin
        frame_err_d = (frame_err_q & ~clr_err) | fe_set;
        overrun_d   = (overrun_q & ~clr_err) | ovr_set;
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: serial driver, queue-based reference model and a monitor
// that checks every byte the DUT hands out on a read.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 1000000;
    localparam int DIV      = 100;
    localparam int DEPTH    = 16;
    // Stop bit starts at a negedge; the DUT samples it 52.5 cycles later.
    localparam int STOP_SAMPLE = 52;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes in order plus the two sticky flags.
    logic [7:0] exp_q[$];
    bit         exp_fe = 1'b0;
    bit         exp_ovr = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err),
        .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back(b);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    // Compare all visible status against the model; called at a negedge.
    task automatic check_status(input string tag);
        chk({tag, ".count"}, int'(count), exp_q.size());
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(exp_q.size() != 0));
        chk({tag, ".frame_err"}, int'(frame_err), int'(exp_fe));
        chk({tag, ".overrun"}, int'(overrun), int'(exp_ovr));
        if (exp_q.size() == 0) chk({tag, ".rd_data_empty"}, int'(rd_data), 0);
        else chk({tag, ".head"}, int'(rd_data), int'(exp_q[0]));
    endtask

    // Send one 8N1 frame starting at the current negedge. bad_stop holds the
    // line low for two bit times; rd_at_push pulses rd_en in the push cycle;
    // rst_bit >= 0 pulses rstn low halfway through that data bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_stop,
                              input bit rd_at_push, input int rst_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (rst_bit == i) begin
                repeat (50) @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                model_reset();
                repeat (DIV - 51) @(negedge clk);
            end else begin
                repeat (DIV) @(negedge clk);
            end
        end
        if (bad_stop) begin
            rx = 1'b0;
            repeat (STOP_SAMPLE + 1) @(negedge clk);
            if (rst_bit < 0) exp_fe = 1'b1;
            repeat (2 * DIV - STOP_SAMPLE - 1) @(negedge clk);
            rx = 1'b1;
            repeat (DIV) @(negedge clk);
        end else begin
            rx = 1'b1;
            repeat (STOP_SAMPLE) @(negedge clk);
            if (rd_at_push) rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            if (rst_bit < 0) model_push(b);
            repeat (DIV - STOP_SAMPLE - 1) @(negedge clk);
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    // Monitor: every accepted read must return the model's oldest byte.
    always begin
        @(negedge clk);
        #2;
        if (rstn && rd_en) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", int'(rd_valid), 0);
                end else begin
                    chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                end
            end else if (exp_q.size() != 0) begin
                chk("missing_rd_valid", int'(rd_valid), 1);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int n;
        int k;
        logic [7:0] b;
        bit bad;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_status("in_reset");
        rstn = 1'b1;
        @(negedge clk);
        check_status("after_reset");

        // Single byte then read it back.
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        check_status("a5");
        pop_n(1);
        check_status("a5_popped");
        pop_n(1);
        check_status("pop_empty");

        // Short glitch must not start a frame.
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
        check_status("glitch");

        // Framing error, recovery, clear.
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check_status("frame_err");
        send_frame(8'h55, 1'b0, 1'b0, -1);
        check_status("after_fe");
        clear_errors();
        check_status("clr_fe");
        pop_n(1);

        // 17 back-to-back bytes: last one overruns.
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b0, -1);
        check_status("overrun");
        pop_n(16);
        check_status("drained");
        clear_errors();
        check_status("clr_ovr");

        // Full FIFO with a read landing in the push cycle of the 17th byte.
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, -1);
        check_status("full");
        send_frame(8'h77, 1'b0, 1'b1, -1);
        check_status("push_pop_full");
        pop_n(16);
        check_status("drained2");

        // Reset mid-frame discards state and the partial byte.
        send_frame(8'h99, 1'b0, 1'b0, -1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        check_status("pre_reset");
        send_frame(8'hFF, 1'b0, 1'b0, 4);
        check_status("mid_reset");
        send_frame(8'h12, 1'b0, 1'b0, -1);
        check_status("after_reset_rx");
        pop_n(1);

        // Randomised bursts with occasional framing errors and partial drains.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                b   = 8'($urandom_range(0, 255));
                bad = ($urandom_range(0, 4) == 0);
                send_frame(b, bad, 1'b0, -1);
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
            check_status("rand_burst");
            k = $urandom_range(0, exp_q.size());
            pop_n(k);
            check_status("rand_drain");
            if (exp_fe) clear_errors();
        end
        pop_n(exp_q.size());
        check_status("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
